aes256_iter_encrypt: RTL and testbench
======================================

Name: aes256_iter_encrypt

Overview:
- Iterative AES-256 encryption engine (FIPS-197), one cipher round per clock, with round keys generated on the fly.
- Free-running: it captures the plaintext and key presented at its inputs, encrypts them, and registers the ciphertext on the output.
- It then immediately captures the next inputs.
- It is the top-level cipher datapath. There is no handshake; software and benches treat the output as "latest completed block".

Parameters:
- NK__KEY_LENGTH, 8, key length in 32-bit words; fixed at 8 (AES-256).
- NR__ROUNDS, 14, maximum and default round count.
- NB__BLOCK_LENGTH_IN_TEXT, 4, block length in 32-bit words.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- user_plain_txt_in  input  NB*32 (128)  plaintext; bit 127 is byte 0 MSB (FIPS byte order, column-major state).
- cipher_key_in  input  NK*32 (256)  cipher key; bits [255:224] are w0.
- rounds_for_encryption_in  input  NR-1 (13)  requested round count, sampled at capture.
- cipher_encrypted_text_out  output  NB*NK*4 (128)  registered ciphertext, same byte order as the plaintext.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - state, key registers and round counter clear to 0.
  - cipher_encrypted_text_out = 0.
  - FSM goes to LOAD.
- FSM states: LOAD, ROUND.
- LOAD (1 cycle):
  - state <= plaintext XOR key[255:128] (round key 0).
  - Key pipeline register <= cipher_key_in.
  - R <= rounds_for_encryption_in; any value of 0 or greater than 14 is replaced by 14.
  - Round counter <= 1; go to ROUND.
- ROUND r, for r = 1..R:
  - Apply SubBytes, ShiftRows, MixColumns (MixColumns omitted when r==R), then AddRoundKey with round key r.
  - Round key 1 = key[127:0].
  - For r >= 2, round key r is the next 4 words from the standard AES-256 schedule, computed combinationally from the previous 8 words held in a 256-bit sliding register:
    - Even r: temp = SubWord(RotWord(w[i-1])) XOR Rcon[r/2].
    - Odd r: temp = SubWord(w[i-1]).
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40.
- S-box: combinational, implemented as GF(2^8) inverse (poly 0x11B, inverse of 0 = 0) followed by the affine transform with constant 0x63. No lookup ROM is required; a ROM is also acceptable.
- Completion: on the r==R cycle, the final state is written to cipher_encrypted_text_out and the FSM returns to LOAD.
- Latency: LOAD plus R rounds, i.e. 15 clocks for R=14.
- Throughput: one block per 15 clocks.
- Output holds its value between completions.
- Input changes during ROUND are ignored until the next LOAD.
- Reset asserted mid-operation aborts the block immediately; no partial result is ever output.
- After reset is released, the first LOAD occurs on the first rising edge with rst_in=1.

Optional Feature:
- Macro AES_DONE_PULSE_EN.
- When defined:
  - Adds output port done_out (1 bit).
  - done_out is registered and is high for exactly one clock, the cycle after cipher_encrypted_text_out updates.
  - Reset value 0.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst_in=0 for 3 clocks -> cipher_encrypted_text_out == 0 throughout; release -> LOAD on the next edge.
- FIPS-197 C.3:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, pt 00112233445566778899aabbccddeeff, rounds 14.
  - Required: output 8ea2b7ca516745bfeafc49904b496089 exactly 15 clocks after LOAD, held until the next completion.
- Rounds clamping: rounds input 0, then 15 -> same result as rounds 14 (8ea2...6089 for the C.3 vector).
- Input change mid-block: change pt to 66778899aabbccddeeff001122334455 on the 6th clock of a block.
  - First completion still yields the C.3 ciphertext.
  - The next block's result matches the software AES-256 model for the new pt.
- Reset mid-operation: assert rst_in at round 7 -> output drops to 0 asynchronously; after release, a full 15-clock block completes with the correct ciphertext.
- With AES_DONE_PULSE_EN defined: done_out pulses once per block, period 15 clocks, aligned one cycle after each output update.

Source files
------------

// File: rtl/aes256_iter_encrypt.sv
// aes256_iter_encrypt: iterative AES-256 encryptor, one round per clock.
// `define AES_DONE_PULSE_EN adds a registered done_out completion pulse.
module aes256_iter_encrypt #(
  parameter int NK__KEY_LENGTH           = 8,
  parameter int NR__ROUNDS               = 14,
  parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic [NB__BLOCK_LENGTH_IN_TEXT*32-1:0] user_plain_txt_in,
  input  logic [NK__KEY_LENGTH*32-1:0] cipher_key_in,
  input  logic [NR__ROUNDS-2:0] rounds_for_encryption_in,
  output logic [NB__BLOCK_LENGTH_IN_TEXT*NK__KEY_LENGTH*4-1:0]
               cipher_encrypted_text_out
`ifdef AES_DONE_PULSE_EN
  ,
  output logic done_out
`endif
);

  localparam int RW = NR__ROUNDS - 1;
  localparam logic [RW-1:0] R_MAX_W = RW'(NR__ROUNDS);
  localparam logic [3:0] R_MAX = 4'(NR__ROUNDS);

  typedef enum logic {LOAD, ROUND} fsm_e;

  fsm_e fsm_q, fsm_d;

  logic [127:0] state_q;
  logic [255:0] key_q;
  logic [127:0] ct_q;
  logic [3:0]   rnd_q;
  logic [3:0]   rmax_q;
  logic [3:0]   rmax_d;

  logic load_en, rnd_en, fin, last;

  logic [127:0] sb, sr, mc, rk, nxt;
  logic [31:0]  wl, tmp, nw0, nw1, nw2, nw3;
  logic [7:0]   rcon;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // x^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, v, b;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    v    = gmul(x15, x15);
    v    = gmul(v, v);
    v    = gmul(v, v);
    x240 = gmul(v, v);
    b    = gmul(gmul(x240, x12), x2);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) fsm_q <= LOAD;
    else         fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      LOAD:  fsm_d = ROUND;
      ROUND: if (last) fsm_d = LOAD;
      default: fsm_d = LOAD;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    rnd_en  = 1'b0;
    fin     = 1'b0;
    unique case (fsm_q)
      LOAD:  load_en = 1'b1;
      ROUND: begin
        rnd_en = 1'b1;
        fin    = last;
      end
      default: load_en = 1'b0;
    endcase
  end

  assign last = (rnd_q == rmax_q);

  assign rmax_d = (rounds_for_encryption_in == '0 ||
                   rounds_for_encryption_in > R_MAX_W)
                  ? R_MAX : rounds_for_encryption_in[3:0];

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int k = 0; k < 16; k++)
      sb[127-8*k -: 8] = sbox(state_q[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mixcol(sr[127-32*c -: 32]);
  end

  // sliding window holds the previous eight schedule words
  always_comb begin
    unique case (rnd_q[3:1])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
    wl  = key_q[31:0];
    tmp = rnd_q[0] ? subw(wl)
                   : subw({wl[23:0], wl[31:24]}) ^ {rcon, 24'h0};
    nw0 = key_q[255:224] ^ tmp;
    nw1 = key_q[223:192] ^ nw0;
    nw2 = key_q[191:160] ^ nw1;
    nw3 = key_q[159:128] ^ nw2;
    rk  = (rnd_q == 4'd1) ? key_q[127:0] : {nw0, nw1, nw2, nw3};
    nxt = (last ? sr : mc) ^ rk;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= '0;
      key_q   <= '0;
      rnd_q   <= '0;
      rmax_q  <= '0;
      ct_q    <= '0;
    end else if (load_en) begin
      state_q <= user_plain_txt_in ^ cipher_key_in[255:128];
      key_q   <= cipher_key_in;
      rmax_q  <= rmax_d;
      rnd_q   <= 4'd1;
    end else if (rnd_en) begin
      state_q <= nxt;
      rnd_q   <= rnd_q + 4'd1;
      if (rnd_q != 4'd1) key_q <= {key_q[127:0], nw0, nw1, nw2, nw3};
      if (fin) ct_q <= nxt;
    end
  end

  assign cipher_encrypted_text_out = ct_q;

`ifdef AES_DONE_PULSE_EN
  logic done_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) done_q <= 1'b0;
    else         done_q <= fin;
  end

  assign done_out = done_q;
`endif

endmodule

// File: tb/tb_aes256_iter_encrypt.sv
// tb_aes256_iter_encrypt: directed checks of the iterative AES-256 engine.
// Reference ciphertexts come from FIPS-197 C.3 and a byte-level AES model.
module tb_aes256_iter_encrypt;

  localparam logic [255:0] KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_B = 128'h66778899aabbccddeeff001122334455;
  localparam logic [127:0] CT_A = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic [127:0] pt;
  logic [255:0] key;
  logic [12:0]  rnds;
  logic [127:0] ct;
`ifdef AES_DONE_PULSE_EN
  logic         done;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] prev;
  logic [7:0]   sbox_t [256];

  aes256_iter_encrypt dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .user_plain_txt_in        (pt),
    .cipher_key_in            (key),
    .rounds_for_encryption_in (rnds),
    .cipher_encrypted_text_out(ct)
`ifdef AES_DONE_PULSE_EN
    ,
    .done_out                 (done)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  // classic generator-walk S-box construction
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]],
            sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] p,
                                         input logic [255:0] k,
                                         input int nr);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = m_subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = m_subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = t[4*((c+j)%4)+j];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // entered on a negedge whose next posedge is a LOAD
  task automatic blk(input string tag, input logic [127:0] p,
                     input logic [12:0] r, input int reff,
                     input logic [127:0] exp);
    pt   = p;
    rnds = r;
    repeat (reff) @(negedge clk_in);
    chk({tag, "_early"}, ct, prev);
`ifdef AES_DONE_PULSE_EN
    chk({tag, "_done_lo"}, {127'd0, done}, 128'd0);
`endif
    @(negedge clk_in);
    chk(tag, ct, exp);
`ifdef AES_DONE_PULSE_EN
    chk({tag, "_done_hi"}, {127'd0, done}, 128'd1);
`endif
    prev = exp;
  endtask

  initial begin
    build_sbox();
    pt   = PT_A;
    key  = KEY;
    rnds = 13'd14;
    repeat (3) begin
      @(negedge clk_in);
      chk("rst_hold", ct, 128'd0);
    end
    rst_in = 1'b1;
    prev   = '0;

    blk("c3", PT_A, 13'd14, 14, CT_A);
    blk("r10_b", PT_B, 13'd10, 10, model(PT_B, KEY, 10));
    blk("clamp0", PT_A, 13'd0, 14, CT_A);
    blk("r1_b", PT_B, 13'd1, 1, model(PT_B, KEY, 1));
    blk("clamp15", PT_A, 13'd15, 14, CT_A);
    blk("r14_b", PT_B, 13'd14, 14, model(PT_B, KEY, 14));
    blk("clamp_max", PT_A, 13'h1fff, 14, CT_A);
    blk("r13_b", PT_B, 13'd13, 13, model(PT_B, KEY, 13));

    pt   = PT_A;
    rnds = 13'd14;
    repeat (5) @(negedge clk_in);
    pt = PT_B;
    repeat (9) @(negedge clk_in);
    chk("mid_early", ct, prev);
    @(negedge clk_in);
    chk("mid_first", ct, CT_A);
    prev = CT_A;
    blk("mid_next", PT_B, 13'd14, 14, model(PT_B, KEY, 14));

    pt = PT_A;
    repeat (8) @(negedge clk_in);
    chk("pre_rst", ct, prev);
    #2 rst_in = 1'b0;
    #1 chk("rst_async", ct, 128'd0);
    @(negedge clk_in);
    chk("rst_mid_hold", ct, 128'd0);
    rst_in = 1'b1;
    prev   = '0;
    blk("post_rst", PT_A, 13'd14, 14, CT_A);

    key = ~KEY;
    blk("key2", PT_A, 13'd14, 14, model(PT_A, ~KEY, 14));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
